// File: rtl/matrix_vector_product.sv
`default_nettype none
// ============================================================================
// Module      : matrix_vector_product
// Description : Tiled multi-cycle unsigned matrix-vector multiplier.
//               TRANSPOSE=0 computes y = M*v, TRANSPOSE=1 computes y = M^T*v.
//               Operands are captured on start; one row-tile (TILING_H
//               columns) is processed per cycle into per-output accumulators.
// Revision    : 1.0 - initial release
// ============================================================================
module matrix_vector_product #(
    parameter int VECTOR_SIZE = 5,
    parameter int CELL_WIDTH  = 8,
    parameter int TILING_H    = 4,
    parameter int ACC_WIDTH   = 2*CELL_WIDTH+3,
    parameter int TRANSPOSE   = 0
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      start,
    input  logic [VECTOR_SIZE*VECTOR_SIZE*CELL_WIDTH-1:0] m,
    input  logic [VECTOR_SIZE*CELL_WIDTH-1:0]         v,
    output logic [VECTOR_SIZE*ACC_WIDTH-1:0]          result,
    output logic                                      busy,
    output logic                                      finish
);

    // Number of column tiles per row and counter widths.
    localparam int NT = (VECTOR_SIZE + TILING_H - 1) / TILING_H;
    localparam int RW = (VECTOR_SIZE > 1) ? $clog2(VECTOR_SIZE) : 1;
    localparam int TW = (NT > 1) ? $clog2(NT) : 1;
    localparam int PW = 2*CELL_WIDTH;

    localparam logic [RW-1:0] LAST_R = RW'(VECTOR_SIZE-1);
    localparam logic [TW-1:0] LAST_C = TW'(NT-1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [RW-1:0] r_q, r_d;
    logic [TW-1:0] c_q, c_d;
    logic          finish_q;
    logic          w_accept;
    logic          w_run;
    logic          w_last;

    // Captured operands; packed so m_q[r][j] matches the row-major input layout.
    logic [VECTOR_SIZE-1:0][VECTOR_SIZE-1:0][CELL_WIDTH-1:0] m_q;
    logic [VECTOR_SIZE-1:0][CELL_WIDTH-1:0]                  v_q;

    // State and row/tile counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            r_q     <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            c_q     <= c_d;
        end
    end

    // Next state: walk tiles within a row, then rows, returning to IDLE after the last tile.
    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        c_d     = c_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    r_d     = '0;
                    c_d     = '0;
                end
            end
            S_RUN: begin
                if (c_q == LAST_C) begin
                    c_d = '0;
                    if (r_q == LAST_R) begin
                        r_d     = '0;
                        state_d = S_IDLE;
                    end else begin
                        r_d = r_q + RW'(1);
                    end
                end else begin
                    c_d = c_q + TW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Decoded controls derived from the current state.
    always_comb begin
        w_run    = (state_q == S_RUN);
        w_accept = (state_q == S_IDLE) && start;
        w_last   = w_run && (r_q == LAST_R) && (c_q == LAST_C);
        busy     = w_run;
    end

    // Operand capture on the accepting edge; later input changes are ignored.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_q <= '0;
            v_q <= '0;
        end else if (w_accept) begin
            m_q <= m;
            v_q <= v;
        end
    end

    // Sticky completion flag, cleared by the next accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            finish_q <= 1'b0;
        end else if (w_accept) begin
            finish_q <= 1'b0;
        end else if (w_last) begin
            finish_q <= 1'b1;
        end
    end

    assign finish = finish_q;

    if (TRANSPOSE == 0) begin : g_fwd
        // Each lane picks its product for the current tile; padding lanes read 0.
        for (genvar t = 0; t < TILING_H; t++) begin : g_lane
            logic [NT-1:0][PW-1:0] w_cand;
            logic [ACC_WIDTH-1:0]  w_part;
            for (genvar cc = 0; cc < NT; cc++) begin : g_tile
                localparam int J = cc*TILING_H + t;
                if (J < VECTOR_SIZE) begin : g_valid
                    assign w_cand[cc] = PW'(m_q[r_q][J]) * PW'(v_q[J]);
                end else begin : g_pad
                    assign w_cand[cc] = '0;
                end
            end
            // Running sum across lanes forms the single adder tree for the row.
            if (t == 0) begin : g_first
                assign w_part = ACC_WIDTH'(w_cand[c_q]);
            end else begin : g_next
                assign w_part = g_lane[t-1].w_part + ACC_WIDTH'(w_cand[c_q]);
            end
        end

        for (genvar k = 0; k < VECTOR_SIZE; k++) begin : g_acc
            logic [ACC_WIDTH-1:0] acc_q;
            // Row k accumulates the lane sum while the sweep is on row k.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc_q <= '0;
                end else if (w_accept) begin
                    acc_q <= '0;
                end else if (w_run && (r_q == RW'(k))) begin
                    acc_q <= acc_q + g_lane[TILING_H-1].w_part;
                end
            end
            assign result[k*ACC_WIDTH +: ACC_WIDTH] = acc_q;
        end
    end else begin : g_tr
        for (genvar k = 0; k < VECTOR_SIZE; k++) begin : g_acc
            // Output k is fed only by lane k%TILING_H when tile k/TILING_H is active.
            localparam int KC = k / TILING_H;
            logic [PW-1:0]        w_prod;
            logic [ACC_WIDTH-1:0] acc_q;
            assign w_prod = PW'(m_q[r_q][k]) * PW'(v_q[r_q]);
            // Column k accumulates M[r][k]*v[r] as each row passes its tile.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    acc_q <= '0;
                end else if (w_accept) begin
                    acc_q <= '0;
                end else if (w_run && (c_q == TW'(KC))) begin
                    acc_q <= acc_q + ACC_WIDTH'(w_prod);
                end
            end
            assign result[k*ACC_WIDTH +: ACC_WIDTH] = acc_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_matrix_vector_product.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_vector_product
// Description : Self-checking bench; three instances (forward, transpose,
//               16-bit accumulator) share stimulus and are compared against a
//               plain matrix-arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_vector_product;

    localparam int N    = 5;
    localparam int CW   = 8;
    localparam int TH   = 4;
    localparam int AW   = 2*CW+3;
    localparam int AW16 = 16;
    localparam int LAT  = 10;
    localparam int BUDGET = 40;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               start;
    logic [N*N*CW-1:0]  m;
    logic [N*CW-1:0]    v;
    logic [N*AW-1:0]    res_f, res_t;
    logic [N*AW16-1:0]  res_w;
    logic               busy_f, busy_t, busy_w;
    logic               fin_f, fin_t, fin_w;

    int checks = 0;
    int errors = 0;

    bit [7:0] mm [N][N];
    bit [7:0] vv [N];

    always #5 clk = ~clk;

    matrix_vector_product #(.VECTOR_SIZE(N), .CELL_WIDTH(CW), .TILING_H(TH),
                            .ACC_WIDTH(AW), .TRANSPOSE(0)) u_fwd (
        .clk(clk), .rst_n(rst_n), .start(start), .m(m), .v(v),
        .result(res_f), .busy(busy_f), .finish(fin_f));

    matrix_vector_product #(.VECTOR_SIZE(N), .CELL_WIDTH(CW), .TILING_H(TH),
                            .ACC_WIDTH(AW), .TRANSPOSE(1)) u_tr (
        .clk(clk), .rst_n(rst_n), .start(start), .m(m), .v(v),
        .result(res_t), .busy(busy_t), .finish(fin_t));

    matrix_vector_product #(.VECTOR_SIZE(N), .CELL_WIDTH(CW), .TILING_H(TH),
                            .ACC_WIDTH(AW16), .TRANSPOSE(0)) u_w16 (
        .clk(clk), .rst_n(rst_n), .start(start), .m(m), .v(v),
        .result(res_w), .busy(busy_w), .finish(fin_w));

    // Reference: y = M*v or M^T*v in wide arithmetic, reduced modulo 2^aw.
    function automatic longint unsigned model_y(int k, bit tr, int aw);
        longint unsigned s = 0;
        for (int j = 0; j < N; j++) begin
            if (tr) s += longint'(mm[j][k]) * longint'(vv[j]);
            else    s += longint'(mm[k][j]) * longint'(vv[j]);
        end
        return s % (64'd1 << aw);
    endfunction

    task automatic drive_operands();
        for (int r = 0; r < N; r++)
            for (int j = 0; j < N; j++)
                m[(r*N+j)*CW +: CW] = mm[r][j];
        for (int j = 0; j < N; j++) v[j*CW +: CW] = vv[j];
    endtask

    task automatic set_identity();
        for (int r = 0; r < N; r++) begin
            for (int j = 0; j < N; j++) mm[r][j] = (r == j) ? 8'd1 : 8'd0;
            vv[r] = 8'(r + 1);
        end
    endtask

    // Accept one operation and wait for finish; meddle drives start and zero operands mid-run.
    task automatic run_op(input bit meddle, output int lat, output int busy_cnt,
                          output logic fin_e0);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        fin_e0   = fin_f;
        busy_cnt = (busy_f === 1'b1) ? 1 : 0;
        lat      = -1;
        for (int n = 1; n <= BUDGET; n++) begin
            if (meddle && n == 2) begin
                start = 1'b1;
                m     = '0;
                v     = '0;
            end
            if (meddle && n == 6) start = 1'b0;
            @(posedge clk);
            #1;
            if (fin_f === 1'b1) begin
                lat = n;
                break;
            end
            if (busy_f === 1'b1) busy_cnt++;
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < N; k++) begin
            checks++;
            if (res_f[k*AW +: AW] !== '0 || res_t[k*AW +: AW] !== '0 || res_w[k*AW16 +: AW16] !== '0) begin
                errors++;
                $display("FAIL reset_result y[%0d] got f=%0d t=%0d w=%0d required 0", k,
                         res_f[k*AW +: AW], res_t[k*AW +: AW], res_w[k*AW16 +: AW16]);
            end
        end
        checks++;
        if ({busy_f, busy_t, busy_w, fin_f, fin_t, fin_w} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags got busy=%b%b%b finish=%b%b%b required 0", busy_f, busy_t, busy_w, fin_f, fin_t, fin_w);
        end
    endtask

    task automatic test_identity(input string name);
        int lat, bc;
        logic fe0;
        set_identity();
        drive_operands();
        run_op(1'b0, lat, bc, fe0);
        checks++;
        if (lat !== LAT) begin
            errors++;
            $display("FAIL %s_latency got %0d required %0d", name, lat, LAT);
        end
        checks++;
        if (bc !== LAT) begin
            errors++;
            $display("FAIL %s_busy_cycles got %0d required %0d", name, bc, LAT);
        end
        checks++;
        if ({busy_f, fin_t, fin_w} !== 3'b011) begin
            errors++;
            $display("FAIL %s_end_flags got busy_f=%b fin_t=%b fin_w=%b required 0 1 1", name, busy_f, fin_t, fin_w);
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (res_f[k*AW +: AW] !== AW'(k + 1) || res_t[k*AW +: AW] !== AW'(k + 1)) begin
                errors++;
                $display("FAIL %s_y[%0d] got f=%0d t=%0d required %0d", name, k,
                         res_f[k*AW +: AW], res_t[k*AW +: AW], k + 1);
            end
        end
    endtask

    task automatic test_full_scale();
        int lat, bc;
        logic fe0;
        for (int r = 0; r < N; r++) begin
            for (int j = 0; j < N; j++) mm[r][j] = 8'hFF;
            vv[r] = 8'hFF;
        end
        drive_operands();
        run_op(1'b0, lat, bc, fe0);
        checks++;
        if (lat !== LAT) begin
            errors++;
            $display("FAIL full_latency got %0d required %0d", lat, LAT);
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (res_f[k*AW +: AW] !== 19'd325125 || res_t[k*AW +: AW] !== 19'd325125 ||
                res_w[k*AW16 +: AW16] !== 16'd62981) begin
                errors++;
                $display("FAIL full_y[%0d] got f=%0d t=%0d w=%0d required 325125 325125 62981", k,
                         res_f[k*AW +: AW], res_t[k*AW +: AW], res_w[k*AW16 +: AW16]);
            end
        end
    endtask

    task automatic test_transpose();
        int lat, bc;
        logic fe0;
        for (int r = 0; r < N; r++) begin
            for (int j = 0; j < N; j++) mm[r][j] = 8'(r + 1);
            vv[r] = 8'd1;
        end
        drive_operands();
        run_op(1'b0, lat, bc, fe0);
        for (int k = 0; k < N; k++) begin
            checks++;
            if (res_f[k*AW +: AW] !== AW'(5*(k+1)) || res_t[k*AW +: AW] !== AW'(15)) begin
                errors++;
                $display("FAIL transpose_y[%0d] got f=%0d t=%0d required %0d 15", k,
                         res_f[k*AW +: AW], res_t[k*AW +: AW], 5*(k+1));
            end
        end
    endtask

    task automatic test_partial_tile();
        int lat, bc;
        logic fe0;
        for (int r = 0; r < N; r++) begin
            for (int j = 0; j < N; j++) mm[r][j] = (j == N-1) ? 8'd7 : 8'd0;
            vv[r] = (r == N-1) ? 8'd2 : 8'd0;
        end
        drive_operands();
        run_op(1'b0, lat, bc, fe0);
        for (int k = 0; k < N; k++) begin
            checks++;
            if (res_f[k*AW +: AW] !== AW'(14) || res_t[k*AW +: AW] !== AW'(model_y(k, 1'b1, AW))) begin
                errors++;
                $display("FAIL partial_y[%0d] got f=%0d t=%0d required 14 %0d", k,
                         res_f[k*AW +: AW], res_t[k*AW +: AW], model_y(k, 1'b1, AW));
            end
        end
    endtask

    task automatic test_random(input int iters);
        int lat, bc;
        logic fe0;
        for (int it = 0; it < iters; it++) begin
            for (int r = 0; r < N; r++) begin
                for (int j = 0; j < N; j++) mm[r][j] = 8'($urandom);
                vv[r] = 8'($urandom);
            end
            drive_operands();
            run_op(1'b0, lat, bc, fe0);
            checks++;
            if (lat !== LAT) begin
                errors++;
                $display("FAIL random%0d_latency got %0d required %0d", it, lat, LAT);
            end
            for (int k = 0; k < N; k++) begin
                checks++;
                if (res_f[k*AW +: AW] !== AW'(model_y(k, 1'b0, AW)) ||
                    res_t[k*AW +: AW] !== AW'(model_y(k, 1'b1, AW)) ||
                    res_w[k*AW16 +: AW16] !== AW16'(model_y(k, 1'b0, AW16))) begin
                    errors++;
                    $display("FAIL random%0d_y[%0d] got f=%0d t=%0d w=%0d required %0d %0d %0d", it, k,
                             res_f[k*AW +: AW], res_t[k*AW +: AW], res_w[k*AW16 +: AW16],
                             model_y(k, 1'b0, AW), model_y(k, 1'b1, AW), model_y(k, 1'b0, AW16));
                end
            end
        end
    endtask

    task automatic test_reset_mid_run();
        set_identity();
        drive_operands();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (res_f !== '0 || res_t !== '0 || res_w !== '0 ||
            {busy_f, busy_t, busy_w, fin_f, fin_t, fin_w} !== 6'b0) begin
            errors++;
            $display("FAIL midreset_async got res_f=%h busy=%b finish=%b required 0 0 0", res_f, busy_f, fin_f);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        test_identity("after_reset");
    endtask

    task automatic test_ignored_inputs();
        int lat, bc;
        logic fe0;
        for (int r = 0; r < N; r++) begin
            for (int j = 0; j < N; j++) mm[r][j] = 8'($urandom_range(1, 255));
            vv[r] = 8'($urandom_range(1, 255));
        end
        drive_operands();
        run_op(1'b1, lat, bc, fe0);
        checks++;
        if (lat !== LAT) begin
            errors++;
            $display("FAIL ignored_latency got %0d required %0d", lat, LAT);
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (res_f[k*AW +: AW] !== AW'(model_y(k, 1'b0, AW)) ||
                res_t[k*AW +: AW] !== AW'(model_y(k, 1'b1, AW))) begin
                errors++;
                $display("FAIL ignored_y[%0d] got f=%0d t=%0d required %0d %0d", k,
                         res_f[k*AW +: AW], res_t[k*AW +: AW], model_y(k, 1'b0, AW), model_y(k, 1'b1, AW));
            end
        end
        // The held start must not have been queued once the run ended.
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (busy_f !== 1'b0 || fin_f !== 1'b1) begin
            errors++;
            $display("FAIL ignored_no_restart got busy=%b finish=%b required 0 1", busy_f, fin_f);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bc;
        logic fe0;
        for (int r = 0; r < N; r++) begin
            for (int j = 0; j < N; j++) mm[r][j] = 8'($urandom);
            vv[r] = 8'($urandom);
        end
        drive_operands();
        run_op(1'b0, lat, bc, fe0);
        checks++;
        if (fe0 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_finish_drop got %b required 0", fe0);
        end
        checks++;
        if (lat !== LAT) begin
            errors++;
            $display("FAIL b2b_latency got %0d required %0d", lat, LAT);
        end
        for (int k = 0; k < N; k++) begin
            checks++;
            if (res_f[k*AW +: AW] !== AW'(model_y(k, 1'b0, AW)) ||
                res_w[k*AW16 +: AW16] !== AW16'(model_y(k, 1'b0, AW16))) begin
                errors++;
                $display("FAIL b2b_y[%0d] got f=%0d w=%0d required %0d %0d", k,
                         res_f[k*AW +: AW], res_w[k*AW16 +: AW16], model_y(k, 1'b0, AW), model_y(k, 1'b0, AW16));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        m     = '0;
        v     = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_reset();
        test_identity("identity");
        test_full_scale();
        test_transpose();
        test_partial_tile();
        test_random(4);
        test_reset_mid_run();
        test_ignored_inputs();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
